// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a multiplexed seven-segment scan bus.
// Each digit is accepted after STABLE_CYC identical registered samples.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned DIGITS     = 4
) (
  input  logic                  clkI,
  input  logic                  rstI,
  input  logic [0:7]            segI,
  input  logic [DIGITS-1:0]     digI,
  output logic [4*DIGITS-1:0]   numO,
  output logic [DIGITS-1:0]     dpO,
  output logic [DIGITS-1:0]     vldO,
  output logic [DIGITS-1:0]     errO,
  output logic                  updO,
  output logic                  frameO
);

  localparam int unsigned CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StHeld
  } state_e;

  // Returns {illegal, nibble}; segment order is {a,b,c,d,e,f,g} with a as MSB.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] res;
    unique case (g)
      7'b1111110: res = 5'h00;
      7'b0110000: res = 5'h01;
      7'b1101101: res = 5'h02;
      7'b1111001: res = 5'h03;
      7'b0110011: res = 5'h04;
      7'b1011011: res = 5'h05;
      7'b1011111: res = 5'h06;
      7'b1110000: res = 5'h07;
      7'b1111111: res = 5'h08;
      7'b1111011: res = 5'h09;
      7'b1110111: res = 5'h0A;
      7'b0011111: res = 5'h0B;
      7'b1001110: res = 5'h0C;
      7'b0111101: res = 5'h0D;
      7'b1001111: res = 5'h0E;
      7'b1000111: res = 5'h0F;
      default:    res = 5'h10;
    endcase
    return res;
  endfunction

  logic [0:7]          r_seg;
  logic [DIGITS-1:0]   r_dig;
  state_e              r_state;
  state_e              w_state_d;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_d;
  logic [0:7]          r_ref_seg;
  logic [0:7]          w_ref_seg_d;
  logic [DIGITS-1:0]   r_ref_dig;
  logic [DIGITS-1:0]   w_ref_dig_d;

  logic [4*DIGITS-1:0] r_num;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_vld;
  logic [DIGITS-1:0]   r_err;
  logic [DIGITS-1:0]   r_seen;
  logic                r_upd;
  logic                r_frame;

  logic                w_onehot;
  logic                w_same;
  logic                w_cap;
  logic [DIGITS-1:0]   w_cap_mask;
  logic [6:0]          w_glyph;
  logic [4:0]          w_dec;
  logic                w_all_seen;

  assign w_onehot   = $onehot(r_dig);
  assign w_same     = (r_seg == r_ref_seg) && (r_dig == r_ref_dig);
  assign w_glyph    = r_seg[0:6];
  assign w_dec      = decode_glyph(w_glyph);
  assign w_cap_mask = w_cap ? r_dig : '0;
  assign w_all_seen = &r_seen;

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      r_seg     <= '0;
      r_dig     <= '0;
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_ref_seg <= '0;
      r_ref_dig <= '0;
    end else begin
      r_seg     <= segI;
      r_dig     <= digI;
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_ref_seg <= w_ref_seg_d;
      r_ref_dig <= w_ref_dig_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_ref_seg_d = r_ref_seg;
    w_ref_dig_d = r_ref_dig;
    w_cap       = 1'b0;

    if ((r_state == StIdle || !w_same) && !w_onehot) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else if (r_state == StIdle || !w_same) begin
      // New one-hot sample: it becomes the reference and the dwell restarts.
      w_ref_seg_d = r_seg;
      w_ref_dig_d = r_dig;
      w_cnt_d     = CNT_ONE;
      if (CNT_ONE == CNT_MAX) begin
        w_cap     = 1'b1;
        w_state_d = StHeld;
      end else begin
        w_state_d = StCount;
      end
    end else if (r_state == StCount) begin
      if (r_cnt != CNT_MAX) begin
        w_cnt_d = r_cnt + CNT_ONE;
      end
      if (w_cnt_d == CNT_MAX) begin
        w_cap     = 1'b1;
        w_state_d = StHeld;
      end
    end
  end

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      r_num   <= '0;
      r_dp    <= '0;
      r_vld   <= '0;
      r_err   <= '0;
      r_seen  <= '0;
      r_upd   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_upd   <= w_cap;
      r_frame <= w_all_seen;
      // A capture landing on the clearing cycle still counts toward the next frame.
      r_seen  <= w_all_seen ? w_cap_mask : (r_seen | w_cap_mask);
      for (int k = 0; k < DIGITS; k++) begin
        if (w_cap_mask[k]) begin
          r_num[4*k +: 4] <= w_dec[3:0];
          r_dp[k]         <= r_seg[7];
          r_vld[k]        <= 1'b1;
          r_err[k]        <= w_dec[4];
        end
      end
    end
  end

  assign numO   = r_num;
  assign dpO    = r_dp;
  assign vldO   = r_vld;
  assign errO   = r_err;
  assign updO   = r_upd;
  assign frameO = r_frame;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYC, default 4, min 1: consecutive identical samples needed to accept a digit.
REQ-002 Parameter DIGITS, default 4: number of multiplexed digit positions.
REQ-003 clkI  input  1  single clock; all state changes on rising edge.
REQ-004 rstI  input  1  asynchronous, active-high reset.
REQ-005 segI  input  [0:7]  segment bus, active-high; bit0=a ... bit6=g, bit7=dp.
REQ-006 digI  input  DIGITS  digit-select strobe, active-high, expected one-hot.
REQ-007 numO  output  4*DIGITS  recovered hex nibble per digit, digit k at bits [4k+3:4k].
REQ-008 dpO  output  DIGITS  recovered decimal point per digit.
REQ-009 vldO  output  DIGITS  digit k has been captured at least once since reset.
REQ-010 errO  output  DIGITS  last capture of digit k was not a legal glyph.
REQ-011 updO  output  1  one-cycle pulse on every capture.
REQ-012 frameO  output  1  one-cycle pulse when every digit has been captured since the previous frameO.

Function
REQ-013 Inputs segI, digI SHALL be registered once before use; all latencies below count from that register.
REQ-014 Legal glyphs on a..g SHALL decode as: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F.
REQ-015 Decoding SHALL ignore dp; dp SHALL be captured independently into dpO[k].
REQ-016 FSM states: IDLE, COUNT, HELD.
REQ-017 IDLE: registered digI not exactly one-hot; counter cleared; no capture.
REQ-018 IDLE->COUNT when registered digI is one-hot; counter loads 1; current {segI,digI} become reference sample.
REQ-019 COUNT: counter increments each cycle the sample equals the reference; on any mismatch the reference reloads and counter restarts at 1 (stay COUNT if still one-hot, else IDLE).
REQ-020 COUNT->HELD on the cycle counter reaches STABLE_CYC; capture occurs that same cycle (STABLE_CYC=1 captures on first one-hot sample).
REQ-021 Capture of digit k SHALL write numO nibble, dpO[k], set vldO[k], set errO[k] for illegal glyph (nibble written 0), clear errO[k] for legal glyph, pulse updO.
REQ-022 HELD: no further capture while sample equals reference; mismatch -> COUNT (one-hot) or IDLE (not one-hot).
REQ-023 Outputs of captured digits SHALL hold until that digit is recaptured or reset.
REQ-024 A per-digit seen mask SHALL set on capture; when mask becomes all-ones, frameO pulses the next cycle and mask clears, except the capturing digit's bit if a capture coincides with the clear.
REQ-025 Counter SHALL saturate at STABLE_CYC; width ceil(log2(STABLE_CYC+1)).
REQ-026 Recapturing the same digit before others SHALL not advance frame completion.

Reset
REQ-027 rstI high SHALL immediately force: state IDLE, counter 0, numO 0, dpO 0, vldO 0, errO 0, updO 0, frameO 0, seen mask 0, input registers 0.
REQ-028 Reset asserted mid-COUNT SHALL abort the pending capture; first capture after release requires a full STABLE_CYC dwell.

Verification
REQ-029 Reset, then digI=0001, segI=1101101_0 held 4 cycles -> updO one pulse, numO[3:0]=2, dpO[0]=0, vldO=0001, errO=0000.
REQ-030 digI=0100, segI=0111101_1 held 3 cycles then segI changes -> no capture; held 4 further cycles stable -> numO[11:8]=D, dpO[2]=1.
REQ-031 Scan digits 0..3 with glyphs 0,7,A,F, 6-cycle dwell each -> four updO pulses, numO=16'hFA70, frameO one pulse one cycle after digit 3 capture.
REQ-032 digI=0011 for 10 cycles -> no updO, outputs unchanged; digI=0010 segI=1010101_0 4 cycles -> errO[1]=1, numO[7:4]=0, vldO[1]=1.
REQ-033 Digit 1 held 20 stable cycles -> exactly one updO; rstI pulsed at counter=3 -> all outputs 0, no capture until 4 new stable cycles.
